// File: rtl/axi_lite_sram_slave_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_sram_slave_pkg
// Shared definitions for the AXI4-Lite SRAM responder: response codes, the
// read/write FSM state encodings and the size of the backing word store.
// -----------------------------------------------------------------------------
package axi_lite_sram_slave_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Backing store holds 2**MEM_AW words; the index is taken from
    // address bits [MEM_AW+1:2], so the store aliases every 4 KiB.
    localparam int MEM_AW    = 10;
    localparam int MEM_WORDS = 1 << MEM_AW;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/axi_lite_sram_slave_lat.sv
// -----------------------------------------------------------------------------
// axi_lite_sram_slave_lat
// Latency down-counter used by each FSM of the SRAM responder.
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : load LAT-1+extra_i into the counter
//   extra_i      : extra delay cycles (0 when random delay is disabled)
//   zero_load_o  : the value being loaded is zero (skip the wait state)
//   last_o       : current count is 1, so the wait ends on this edge
// -----------------------------------------------------------------------------
module axi_lite_sram_slave_lat
    import axi_lite_sram_slave_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [2:0] extra_i,
    output logic       zero_load_o,
    output logic       last_o
);

    localparam int CW = $clog2(LAT + 8);

    logic [CW-1:0] cnt_q, cnt_d, load_val;

    assign load_val    = CW'(LAT - 1) + CW'(extra_i);
    assign zero_load_o = (load_val == '0);
    assign last_o      = (cnt_q == CW'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_sram_slave
// AXI4-Lite responder in front of a word-addressed memory model. Independent
// read and write FSMs, each with a fixed access latency (RD_LAT / WR_LAT).
// Define SRAM_RAND_DELAY_EN to add 0..7 pseudo-random extra cycles per access
// from a shared 4-bit LFSR (x^4+x^3+1, seed 4'b1001).
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   awaddr/awvalid/awready          : write address channel
//   wdata/wstrb/wvalid/wready       : write data channel
//   bresp/bvalid/bready             : write response channel
//   araddr/arvalid/arready          : read address channel
//   rdata/rresp/rvalid/rready       : read data channel
// Address bits [1:0] are ignored; all accesses are whole-word.
// -----------------------------------------------------------------------------
module axi_lite_sram_slave
    import axi_lite_sram_slave_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);

    logic [31:0] mem [MEM_WORDS];
    logic [2:0]  rnd;

`ifdef SRAM_RAND_DELAY_EN
    logic [3:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 4'b1001;
        end else begin
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end
    assign rnd = lfsr_q[2:0];
`else
    assign rnd = 3'd0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr[31:MEM_AW+2], araddr[1:0],
                                awaddr[31:MEM_AW+2], awaddr[1:0]};

    // ---------------- read path ----------------
    rd_state_e         rd_state_q, rd_state_d;
    logic [MEM_AW-1:0] rd_idx_q, rd_idx_d, rd_idx_now;
    logic [31:0]       rdata_q, rdata_d;
    logic              ar_hs, rd_load, rd_zero, rd_last, rd_fire;

    assign arready = (rd_state_q == R_IDLE);
    assign ar_hs   = arvalid && arready;
    // With a zero-cycle wait the word is fetched on the handshake edge itself,
    // before the address has been latched.
    assign rd_idx_now = (rd_state_q == R_IDLE) ? araddr[MEM_AW+1:2] : rd_idx_q;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_load    = 1'b0;
        rd_fire    = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_idx_d = araddr[MEM_AW+1:2];
                    rd_load  = 1'b1;
                    if (rd_zero) begin
                        rd_state_d = R_RESP;
                        rd_fire    = 1'b1;
                    end else begin
                        rd_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rd_last) begin
                    rd_state_d = R_RESP;
                    rd_fire    = 1'b1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        rdata_d = rd_fire ? mem[rd_idx_now] : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_idx_q <= rd_idx_d;
    end

    axi_lite_sram_slave_lat #(.LAT(RD_LAT)) u_rd_lat (
        .clk         (clk),
        .rst         (rst),
        .load_i      (rd_load),
        .extra_i     (rnd),
        .zero_load_o (rd_zero),
        .last_o      (rd_last)
    );

    assign rvalid = (rd_state_q == R_RESP);
    assign rdata  = rdata_q;
    assign rresp  = RESP_OKAY;

    // ---------------- write path ----------------
    wr_state_e         wr_state_q, wr_state_d;
    logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [MEM_AW-1:0] aw_idx_q, aw_idx_d, wr_idx_now;
    logic [31:0]       w_data_q, w_data_d, wr_data_now, wr_merged;
    logic [3:0]        w_strb_q, w_strb_d, wr_strb_now;
    logic              aw_hs, w_hs, wr_commit, wr_load, wr_zero, wr_last;

    assign awready = (wr_state_q == W_IDLE) && !aw_got_q;
    assign wready  = (wr_state_q == W_IDLE) && !w_got_q;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // The commit happens on the edge that completes the second of the two
    // handshakes, so the just-arriving channel is taken straight off the bus.
    assign wr_idx_now  = aw_got_q ? aw_idx_q : awaddr[MEM_AW+1:2];
    assign wr_data_now = w_got_q  ? w_data_q : wdata;
    assign wr_strb_now = w_got_q  ? w_strb_q : wstrb;
    assign wr_commit   = (wr_state_q == W_IDLE) && (aw_got_q || aw_hs) && (w_got_q || w_hs);

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            wr_merged[8*b +: 8] = wr_strb_now[b] ? wr_data_now[8*b +: 8]
                                                 : mem[wr_idx_now][8*b +: 8];
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        aw_idx_d   = aw_idx_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        wr_load    = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    aw_idx_d = awaddr[MEM_AW+1:2];
                end
                if (w_hs) begin
                    w_got_d  = 1'b1;
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                end
                if (wr_commit) begin
                    aw_got_d   = 1'b0;
                    w_got_d    = 1'b0;
                    wr_load    = 1'b1;
                    wr_state_d = wr_zero ? W_RESP : W_WAIT;
                end
            end
            W_WAIT: begin
                if (wr_last) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
        end
    end

    always_ff @(posedge clk) begin
        aw_idx_q <= aw_idx_d;
        w_data_q <= w_data_d;
        w_strb_q <= w_strb_d;
    end

    // Non-blocking store: a read fetching the same word on this edge still
    // sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_commit && (wr_strb_now != 4'b0000)) begin
            mem[wr_idx_now] <= wr_merged;
        end
    end

    axi_lite_sram_slave_lat #(.LAT(WR_LAT)) u_wr_lat (
        .clk         (clk),
        .rst         (rst),
        .load_i      (wr_load),
        .extra_i     (rnd),
        .zero_load_o (wr_zero),
        .last_o      (wr_last)
    );

    assign bvalid = (wr_state_q == W_RESP);
    assign bresp  = RESP_OKAY;

    // ---------------- protocol checks ----------------
    a_rvalid_hold: assert property (@(posedge clk) disable iff (rst)
        (rvalid && !rready) |=> rvalid);
    a_bvalid_hold: assert property (@(posedge clk) disable iff (rst)
        (bvalid && !bready) |=> bvalid);
    a_rdata_stable: assert property (@(posedge clk) disable iff (rst)
        (rvalid && !rready) |=> $stable(rdata));

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
module tb_axi_lite_sram_slave;

`ifdef SRAM_RAND_DELAY_EN
    localparam int XTRA = 7;
`else
    localparam int XTRA = 0;
`endif
    localparam int RD_LAT  = 1;
    localparam int WR_LAT  = 1;
    localparam int RD_LAT4 = 4;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    logic        rst4;
    logic [31:0] awaddr4 = '0, wdata4 = '0, araddr4, rdata4;
    logic [3:0]  wstrb4 = '0;
    logic        awvalid4 = 1'b0, wvalid4 = 1'b0, bready4 = 1'b1;
    logic        awready4, wready4, bvalid4, arvalid4, arready4, rvalid4, rready4;
    logic [1:0]  bresp4, rresp4;

    int passed = 0;
    int total  = 0;

    axi_lite_sram_slave #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) u_dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    axi_lite_sram_slave #(.RD_LAT(RD_LAT4), .WR_LAT(1)) u_dut4 (
        .clk(clk), .rst(rst4),
        .awaddr(awaddr4), .awvalid(awvalid4), .awready(awready4),
        .wdata(wdata4), .wstrb(wstrb4), .wvalid(wvalid4), .wready(wready4),
        .bresp(bresp4), .bvalid(bvalid4), .bready(bready4),
        .araddr(araddr4), .arvalid(arvalid4), .arready(arready4),
        .rdata(rdata4), .rresp(rresp4), .rvalid(rvalid4), .rready(rready4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) passed++;
        else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input string tag);
        int n, k;
        bit aw_done, w_done, aw_hs, w_hs;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        bready  = 1'b1;
        awvalid = (aw_dly == 0);
        wvalid  = (w_dly == 0);
        aw_done = 1'b0;
        w_done  = 1'b0;
        n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            n++;
            if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
            if (!aw_done && n == aw_dly) awvalid = 1'b1;
            if (!w_done && n == w_dly)   wvalid  = 1'b1;
            if (aw_done && !w_done) chk({tag, "_awready_low"}, {31'd0, awready}, 32'd0);
            if (w_done && !aw_done) chk({tag, "_wready_low"}, {31'd0, wready}, 32'd0);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk({tag, "_accepted"}, {30'd0, aw_done, w_done}, 32'd3);
        k = 1;
        while (!bvalid && k < 20) begin tick(); k++; end
        chk_rng({tag, "_b_latency"}, k, WR_LAT, WR_LAT + XTRA);
        chk({tag, "_bresp"}, {30'd0, bresp}, 32'd0);
        tick();
        chk({tag, "_bvalid_pulse"}, {31'd0, bvalid}, 32'd0);
        chk({tag, "_ready_restored"}, {30'd0, awready, wready}, 32'd3);
    endtask

    task automatic axi_read(input logic [31:0] a, input int stall, input logic [31:0] exp,
                            input string tag);
        int n, k;
        bit hs;
        araddr  = a;
        arvalid = 1'b1;
        rready  = (stall == 0);
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 20) begin
            hs = arvalid && arready;
            tick();
            n++;
        end
        arvalid = 1'b0;
        chk({tag, "_ar_accepted"}, {31'd0, hs}, 32'd1);
        k = 1;
        while (!rvalid && k < 20) begin tick(); k++; end
        chk_rng({tag, "_r_latency"}, k, RD_LAT, RD_LAT + XTRA);
        chk({tag, "_rdata"}, rdata, exp);
        chk({tag, "_rresp"}, {30'd0, rresp}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_stall_rvalid"}, {31'd0, rvalid}, 32'd1);
            chk({tag, "_stall_rdata"}, rdata, exp);
            chk({tag, "_stall_arready"}, {31'd0, arready}, 32'd0);
            tick();
        end
        rready = 1'b1;
        tick();
        chk({tag, "_rvalid_cleared"}, {31'd0, rvalid}, 32'd0);
        chk({tag, "_arready_back"}, {31'd0, arready}, 32'd1);
    endtask

    initial begin
        int k;
        int seen;
        rst = 1'b1;  rst4 = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        araddr4 = '0; arvalid4 = 1'b0; rready4 = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_readies", {29'd0, awready, wready, arready}, 32'd7);
        chk("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
        chk("rst_resps", {28'd0, bresp, rresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst4_arready", {31'd0, arready4}, 32'd1);
        rst = 1'b0;
        rst4 = 1'b0;
        tick();

        // Basic write then read
        axi_write(32'h8000_0000, 32'h0000_0413, 4'b1111, 0, 0, "wr_413");
        axi_read (32'h8000_0000, 0, 32'h0000_0413, "rd_413");

        // AW one cycle ahead of W
        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 1, "wr_aw_first");
        axi_read (32'h8000_0010, 0, 32'hDEAD_BEEF, "rd_deadbeef");

        // W ahead of AW, then partial-strobe merge
        axi_write(32'h8000_0014, 32'h1122_3344, 4'b1111, 1, 0, "wr_w_first");
        axi_write(32'h8000_0014, 32'hAABB_CCDD, 4'b0101, 0, 0, "wr_strb_0101");
        axi_read (32'h8000_0014, 0, 32'h11BB_33DD, "rd_merged");

        // Zero strobe: response but no store; low address bits ignored
        axi_write(32'h8000_0010, 32'h1234_5678, 4'b0000, 0, 0, "wr_strb_none");
        axi_read (32'h8000_0013, 0, 32'hDEAD_BEEF, "rd_unaligned");

        // Read held off by rready=0 for five cycles
        axi_write(32'h8000_0020, 32'hCAFE_F00D, 4'b1111, 0, 0, "wr_cafe");
        axi_read (32'h8000_0020, 5, 32'hCAFE_F00D, "rd_stall");

`ifndef SRAM_RAND_DELAY_EN
        // Same-edge read and write commit to one word: read sees old data
        axi_write(32'h8000_0030, 32'h0000_0001, 4'b1111, 0, 0, "wr_old");
        araddr = 32'h8000_0030; arvalid = 1'b1; rready = 1'b1;
        awaddr = 32'h8000_0030; awvalid = 1'b1;
        wdata = 32'h0000_0002; wstrb = 4'b1111; wvalid = 1'b1; bready = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("coll_rvalid", {31'd0, rvalid}, 32'd1);
        chk("coll_rdata_old", rdata, 32'h0000_0001);
        chk("coll_bvalid", {31'd0, bvalid}, 32'd1);
        tick();
        chk("coll_done", {30'd0, rvalid, bvalid}, 32'd0);
        axi_read(32'h8000_0030, 0, 32'h0000_0002, "rd_new");
`endif

        // Reset while the RD_LAT=4 instance is waiting
        araddr4 = 32'h8000_0040; arvalid4 = 1'b1; rready4 = 1'b1;
        tick();
        arvalid4 = 1'b0;
        chk("lat4_wait_arready", {31'd0, arready4}, 32'd0);
        chk("lat4_wait_rvalid", {31'd0, rvalid4}, 32'd0);
        tick();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        chk("lat4_rst_rvalid", {31'd0, rvalid4}, 32'd0);
        chk("lat4_rst_arready", {31'd0, arready4}, 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (rvalid4) seen++;
            tick();
        end
        chk("lat4_dropped", seen, 32'd0);
        arvalid4 = 1'b1;
        tick();
        arvalid4 = 1'b0;
        k = 1;
        while (!rvalid4 && k < 30) begin tick(); k++; end
        chk_rng("lat4_fresh_latency", k, RD_LAT4, RD_LAT4 + XTRA);
        chk("lat4_fresh_rresp", {30'd0, rresp4}, 32'd0);
        tick();
        chk("lat4_fresh_done", {30'd0, rvalid4, arready4}, 32'd1);

`ifdef SRAM_RAND_DELAY_EN
        for (int i = 0; i < 100; i++) begin
            axi_read(32'h8000_0000, 0, 32'h0000_0413, "rd_rand");
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
